dmem_responder: RTL

- Data-memory responder for the MEM stage of the pipelined RISC-V core; the slave end of the CPU's addr/wdata/MemWrite memory port.
- Accepts CPU loads and stores and posts stores into a small write buffer.
- Drains the buffer lazily into a single-port word array.
- Returns load data one cycle later, forwarding from the buffer on address hit; raises a stall to the CPU when the buffer cannot accept work.

---
 rtl/dmem_responder.sv | 92 +++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with posted-write buffer, lazy drain and load forwarding.
// Define DMEM_PERF_EN to add saturating stall and forward-hit counters.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WB_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        stall,
    output logic        wb_empty
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_fwd_hit_cnt
`endif
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(WB_DEPTH);

    logic [IW-1:0] wb_idx  [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    logic [31:0]   mem     [DEPTH_WORDS];
    logic [PW-1:0] rd_ptr, wr_ptr, pos;
    logic [PW:0]   count;
    logic [IW-1:0] idx;
    logic [31:0]   fwd_data;
    logic          full, push, pop, load, hit;

    assign idx      = addr[2 +: IW];
    assign full     = count == (PW+1)'(WB_DEPTH);
    assign stall    = full && (MemWrite || MemRead);
    assign push     = MemWrite && !full;
    assign load     = MemRead && !MemWrite && !full;
    assign pop      = (count != '0) && (full || !(MemWrite || MemRead));
    assign wb_empty = count == '0;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        pos      = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            pos = rd_ptr + PW'(k);
            if ((PW+1)'(k) < count && wb_idx[pos] == idx) begin
                hit      = 1'b1;
                fwd_data = wb_data[pos];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count       <= count + (PW+1)'(push) - (PW+1)'(pop);
            rdata_valid <= load;
            if (load) rdata <= hit ? fwd_data : mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_idx[wr_ptr]  <= idx;
            wb_data[wr_ptr] <= wdata;
        end
        if (pop) mem[wb_idx[rd_ptr]] <= wb_data[rd_ptr];
    end

`ifdef DMEM_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt   <= '0;
            perf_fwd_hit_cnt <= '0;
        end else begin
            if (stall && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (load && hit && !(&perf_fwd_hit_cnt)) perf_fwd_hit_cnt <= perf_fwd_hit_cnt + 32'd1;
        end
    end
`endif
endmodule
